st_to_mm_fifo_adapter: RTL and testbench
========================================

ST_TO_MM_FIFO_ADAPTER -- requirements
Module: st_to_mm_fifo_adapter

Interface
REQ-001 Parameter WIDTH, default 8, data word width; SHALL be >= 8 and >= $clog2(DEPTH+1).
REQ-002 Parameter DEPTH, default 8, buffer depth in words; SHALL be a power of two, 2..256.
REQ-003 clock  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_ready  output  1  adapter can accept a stream word.
REQ-006 in_valid  input  1  stream word present.
REQ-007 in_data  input  WIDTH  stream data.
REQ-008 in_sop / in_eop  input  1 each  start/end-of-packet markers.
REQ-009 out_read  input  1  MM read strobe.
REQ-010 out_write  input  1  MM write strobe.
REQ-011 out_address  input  2  MM register select.
REQ-012 out_writedata  input  WIDTH  MM write data.
REQ-013 out_waitrequest  output  1  MM stall.
REQ-014 out_readdata  output  WIDTH  MM read data, combinational from current state (zero read latency).

Function
REQ-015 Storage SHALL be a DEPTH-entry circular FIFO of {eop, sop, data}, with read/write pointers wrapping from DEPTH-1 to 0.
REQ-016 Fill level: width $clog2(DEPTH+1), range 0..DEPTH; empty at 0, full at DEPTH.
REQ-017 in_ready SHALL equal !full && !reset.
REQ-018 Push on rising edge when in_valid && in_ready; in_valid while !in_ready SHALL be ignored, with no storage and no error.
REQ-019 Address 0, read: readdata = head data; pop on the edge where out_read && !out_waitrequest.
REQ-020 out_waitrequest SHALL be 1 when out_read && out_address==0 && empty, and 1 while reset is high; otherwise 0.
REQ-021 A stalled address-0 read SHALL complete in the first cycle after a push makes the FIFO non-empty.
REQ-022 Address 1, read: readdata = {zeros, head eop, head sop}, peek only, no pop; 0 when empty.
REQ-023 Address 2, read: readdata = zero-extended fill level.
REQ-024 Address 3, read: readdata bit0 = empty, bit1 = full, bit2 = protocol_error (sticky), bits[WIDTH-1:8] = 0, bits[7:3] = low 5 bits of packets_held.
REQ-025 packets_held SHALL count stored words with eop=1: +1 on push of an eop word, -1 on pop of an eop word, unchanged when both occur in the same cycle.
REQ-026 in_packet flag: set on accepted sop, cleared on accepted eop; a word with sop && eop leaves it 0.
REQ-027 protocol_error SHALL set on an accepted word with sop=1 while in_packet=1, or with sop=0 while in_packet=0; the word is still stored.
REQ-028 Write to address 3 with writedata[0]=1 SHALL clear protocol_error, unless a new error occurs in the same cycle (set wins); all other writes are ignored; writes never stall.
REQ-029 Simultaneous push and pop SHALL leave fill level unchanged and be legal at any non-empty, non-full level.
REQ-030 Read at any address with out_read=0 has no side effect; readdata is don't-care but SHALL be X-free.

Reset
REQ-031 Reset SHALL asynchronously clear pointers, fill level, packets_held, in_packet and protocol_error; FIFO contents need not be cleared.
REQ-032 During reset: in_ready=0, out_waitrequest=1; after reset: in_ready=1, empty=1; reset mid-packet discards all buffered data.

Verification
REQ-033 Push 3 words (0x11 sop, 0x22, 0x33 eop), then read addr 3 -> 0x08; read addr 0 three times -> 0x11, 0x22, 0x33, no stall; addr 2 -> 0.
REQ-034 Push DEPTH words with no reads -> in_ready=0, addr 3 bit1=1; extra in_valid word is dropped; pop one -> in_ready=1 next cycle.
REQ-035 Read addr 0 when empty -> waitrequest=1 held; push 0xA5 -> read completes with 0xA5 the following cycle.
REQ-036 Push two words with sop=0 -> addr 3 bit2=1; write addr 3 data 0x1 -> bit2=0; clear coincident with new error -> bit2 stays 1.
REQ-037 Continuous push and pop at level 4 for 2*DEPTH cycles -> level stays 4, data order preserved across pointer wrap.
REQ-038 Assert reset with 5 words buffered, mid-packet -> in_ready=0 and waitrequest=1 during reset; after reset addr 2 = 0, addr 3 = 0x01.

Source files
------------

// File: rtl/st_to_mm_fifo_adapter.sv
`default_nettype none
// ============================================================================
//  Module   : st_to_mm_fifo_adapter
//  Brief    : Streaming-sink FIFO drained through a 4-register memory-mapped
//             slave (data pop, head flags, fill level, status/control).
//  Revision : 1.0  initial release
// ============================================================================
module st_to_mm_fifo_adapter #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    output logic             in_ready,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sop,
    input  logic             in_eop,
    input  logic             out_read,
    input  logic             out_write,
    input  logic [1:0]       out_address,
    input  logic [WIDTH-1:0] out_writedata,
    output logic             out_waitrequest,
    output logic [WIDTH-1:0] out_readdata
);

    localparam int c_ADDR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W   = $clog2(DEPTH + 1);
    localparam int c_ENTRY_W = WIDTH + 2;

    logic [c_ENTRY_W-1:0] r_mem [DEPTH];
    logic [c_ADDR_W-1:0]  r_wr_ptr;
    logic [c_ADDR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;
    logic [c_CNT_W-1:0]   r_packets_held;
    logic                 r_in_packet;
    logic                 r_protocol_error;

    logic                 w_empty;
    logic                 w_full;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_err_event;
    logic                 w_err_clear;
    logic [c_ENTRY_W-1:0] w_head;
    logic [4:0]           w_ph_low5;
    logic [WIDTH-1:0]     w_readdata;
    logic                 w_unused_ok;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == c_CNT_W'(DEPTH));
    assign w_head   = r_mem[r_rd_ptr];

    assign in_ready        = !w_full && !reset;
    assign out_waitrequest = reset || (out_read && (out_address == 2'd0) && w_empty);

    assign w_push      = in_valid && in_ready;
    assign w_pop       = out_read && (out_address == 2'd0) && !out_waitrequest;
    // An accepted word is a protocol error when its sop disagrees with packet state.
    assign w_err_event = w_push && (in_sop == r_in_packet);
    assign w_err_clear = out_write && (out_address == 2'd3) && out_writedata[0];
    assign w_unused_ok = &{1'b0, out_writedata[WIDTH-1:1]};

    if (c_CNT_W >= 5) begin : g_ph_wide
        assign w_ph_low5 = r_packets_held[4:0];
    end else begin : g_ph_narrow
        assign w_ph_low5 = 5'(r_packets_held);
    end

    always_comb begin
        w_readdata = '0;
        case (out_address)
            2'd0: if (!w_empty) w_readdata = w_head[WIDTH-1:0];
            2'd1: if (!w_empty) w_readdata[1:0] = w_head[WIDTH+1:WIDTH];
            2'd2: w_readdata[c_CNT_W-1:0] = r_count;
            default: w_readdata[7:0] = {w_ph_low5, r_protocol_error, w_full, w_empty};
        endcase
    end
    assign out_readdata = w_readdata;

    // Storage is not reset; the pointers and count alone define validity.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_eop, in_sop, in_data};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr         <= '0;
            r_rd_ptr         <= '0;
            r_count          <= '0;
            r_packets_held   <= '0;
            r_in_packet      <= 1'b0;
            r_protocol_error <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ADDR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ADDR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - c_CNT_W'(1);
            end
            if ((w_push && in_eop) && !(w_pop && w_head[WIDTH+1])) begin
                r_packets_held <= r_packets_held + c_CNT_W'(1);
            end else if (!(w_push && in_eop) && (w_pop && w_head[WIDTH+1])) begin
                r_packets_held <= r_packets_held - c_CNT_W'(1);
            end
            if (w_push) begin
                if (in_eop) begin
                    r_in_packet <= 1'b0;
                end else if (in_sop) begin
                    r_in_packet <= 1'b1;
                end
            end
            if (w_err_event) begin
                r_protocol_error <= 1'b1;
            end else if (w_err_clear) begin
                r_protocol_error <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_st_to_mm_fifo_adapter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_st_to_mm_fifo_adapter
//  Brief    : Directed and randomized bench with a queue-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_st_to_mm_fifo_adapter;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             in_ready;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_sop = 1'b0;
    logic             in_eop = 1'b0;
    logic             out_read = 1'b0;
    logic             out_write = 1'b0;
    logic [1:0]       out_address = 2'd0;
    logic [WIDTH-1:0] out_writedata = '0;
    logic             out_waitrequest;
    logic [WIDTH-1:0] out_readdata;

    st_to_mm_fifo_adapter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock           (clock),
        .reset           (reset),
        .in_ready        (in_ready),
        .in_valid        (in_valid),
        .in_data         (in_data),
        .in_sop          (in_sop),
        .in_eop          (in_eop),
        .out_read        (out_read),
        .out_write       (out_write),
        .out_address     (out_address),
        .out_writedata   (out_writedata),
        .out_waitrequest (out_waitrequest),
        .out_readdata    (out_readdata)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic             eop;
        logic             sop;
        logic [WIDTH-1:0] data;
    } word_t;

    word_t m_q[$];
    bit    m_in_packet = 1'b0;
    bit    m_err = 1'b0;
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_packets_held();
        int n = 0;
        foreach (m_q[i]) if (m_q[i].eop) n++;
        return n;
    endfunction

    function automatic logic [WIDTH-1:0] m_rdata(input logic [1:0] a);
        int n = m_q.size();
        int v = 0;
        case (a)
            2'd0: v = (n > 0) ? int'(m_q[0].data) : 0;
            2'd1: v = (n > 0) ? (int'(m_q[0].eop) * 2 + int'(m_q[0].sop)) : 0;
            2'd2: v = n;
            default: v = (m_packets_held() % 32) * 8 + (m_err ? 4 : 0)
                         + ((n == DEPTH) ? 2 : 0) + ((n == 0) ? 1 : 0);
        endcase
        return WIDTH'(v);
    endfunction

    // Reference model: advances on the same edges as the design.
    always @(posedge clock or posedge reset) begin : m_step
        bit push, pop, err_ev, clr;
        if (reset) begin
            m_q.delete();
            m_in_packet = 1'b0;
            m_err = 1'b0;
        end else begin
            push   = in_valid && (m_q.size() < DEPTH);
            pop    = out_read && (out_address == 2'd0) && (m_q.size() > 0);
            err_ev = push && ((in_sop && m_in_packet) || (!in_sop && !m_in_packet));
            clr    = out_write && (out_address == 2'd3) && out_writedata[0];
            if (pop) void'(m_q.pop_front());
            if (push) m_q.push_back('{eop: in_eop, sop: in_sop, data: in_data});
            if (err_ev) m_err = 1'b1;
            else if (clr) m_err = 1'b0;
            if (push) begin
                if (in_eop) m_in_packet = 1'b0;
                else if (in_sop) m_in_packet = 1'b1;
            end
        end
    end

    always @(negedge clock) begin
        if (reset) begin
            chk("in_ready_in_reset", in_ready, 0);
            chk("waitreq_in_reset", out_waitrequest, 1);
        end else begin
            chk("in_ready", in_ready, (m_q.size() < DEPTH) ? 1 : 0);
            chk("waitrequest", out_waitrequest,
                (out_read && out_address == 2'd0 && m_q.size() == 0) ? 1 : 0);
            if (out_read && !(out_address == 2'd0 && m_q.size() == 0))
                chk("readdata", out_readdata, m_rdata(out_address));
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input logic s, input logic e);
        in_valid = 1'b1; in_data = d; in_sop = s; in_eop = e;
        step();
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    endtask

    task automatic read_expect(input string name, input logic [1:0] a, input logic [7:0] exp);
        out_read = 1'b1; out_address = a;
        @(negedge clock);
        chk(name, out_readdata, exp);
        chk({name, "_stall"}, out_waitrequest, 0);
        step();
        out_read = 1'b0;
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [7:0] d);
        out_write = 1'b1; out_address = a; out_writedata = d;
        step();
        out_write = 1'b0;
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        @(negedge clock);
        chk("lit_rst_in_ready", in_ready, 0);
        chk("lit_rst_waitreq", out_waitrequest, 1);
        step();
        reset = 1'b0;
    endtask

    initial begin
        step();
        step();
        reset = 1'b0;
        @(negedge clock);
        chk("lit_post_reset_ready", in_ready, 1);
        step();
        read_expect("lit_post_reset_status", 2'd3, 8'h01);

        // Three-word packet, then drain it through the data register.
        push(8'h11, 1'b1, 1'b0);
        push(8'h22, 1'b0, 1'b0);
        push(8'h33, 1'b0, 1'b1);
        read_expect("lit_status_one_pkt", 2'd3, 8'h08);
        read_expect("lit_pop0", 2'd0, 8'h11);
        read_expect("lit_pop1", 2'd0, 8'h22);
        read_expect("lit_pop2", 2'd0, 8'h33);
        read_expect("lit_level_empty", 2'd2, 8'h00);

        // Fill to DEPTH, offer one extra word, then free one slot.
        for (int i = 0; i < DEPTH; i++)
            push(8'h80 + 8'(i), (i == 0), (i == DEPTH - 1));
        @(negedge clock);
        chk("lit_full_ready", in_ready, 0);
        step();
        read_expect("lit_full_status", 2'd3, 8'h0A);
        push(8'hEE, 1'b1, 1'b0);
        read_expect("lit_full_head", 2'd0, 8'h80);
        @(negedge clock);
        chk("lit_ready_after_pop", in_ready, 1);
        step();
        for (int i = 1; i < DEPTH; i++)
            read_expect("drain", 2'd0, 8'h80 + 8'(i));

        // Stalled read released by a push.
        out_read = 1'b1; out_address = 2'd0;
        @(negedge clock);
        chk("lit_stall_a", out_waitrequest, 1);
        step();
        @(negedge clock);
        chk("lit_stall_b", out_waitrequest, 1);
        in_valid = 1'b1; in_data = 8'hA5; in_sop = 1'b1; in_eop = 1'b1;
        step();
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
        @(negedge clock);
        chk("lit_stall_release", out_waitrequest, 0);
        chk("lit_stall_data", out_readdata, 8'hA5);
        step();
        out_read = 1'b0;
        read_expect("lit_level_after_stall", 2'd2, 8'h00);

        // Protocol error set, clear, and clear coincident with a new error.
        push(8'h01, 1'b0, 1'b0);
        push(8'h02, 1'b0, 1'b0);
        read_expect("lit_err_set", 2'd3, 8'h04);
        write_reg(2'd3, 8'h01);
        read_expect("lit_err_cleared", 2'd3, 8'h00);
        out_write = 1'b1; out_address = 2'd3; out_writedata = 8'h01;
        in_valid = 1'b1; in_data = 8'h03; in_sop = 1'b0; in_eop = 1'b0;
        step();
        out_write = 1'b0; in_valid = 1'b0;
        read_expect("lit_err_set_wins", 2'd3, 8'h04);
        for (int i = 0; i < 3; i++) read_expect("err_drain", 2'd0, 8'h01 + 8'(i));

        // Steady push+pop at level 4 across pointer wrap.
        for (int i = 0; i < 4; i++) push(8'h30 + 8'(i), 1'b1, 1'b1);
        for (int i = 0; i < 2 * DEPTH; i++) begin
            in_valid = 1'b1; in_data = 8'h40 + 8'(i); in_sop = 1'b1; in_eop = 1'b1;
            out_read = 1'b1; out_address = 2'd0;
            step();
        end
        in_valid = 1'b0; out_read = 1'b0;
        read_expect("lit_level_steady", 2'd2, 8'h04);
        read_expect("lit_wrap_head", 2'd0, 8'h4C);

        // Reset mid-packet with words buffered.
        push(8'h50, 1'b1, 1'b0);
        for (int i = 1; i < 5; i++) push(8'h50 + 8'(i), 1'b0, 1'b0);
        do_reset();
        read_expect("lit_level_after_reset", 2'd2, 8'h00);
        read_expect("lit_status_after_reset", 2'd3, 8'h01);

        // Randomized traffic: push-heavy, then read-heavy, with one reset between.
        for (int i = 0; i < 1600; i++) begin
            bit heavy_push = (i % 400) < 200;
            in_valid      = ($urandom_range(0, 9) < (heavy_push ? 8 : 4));
            in_data       = 8'($urandom);
            in_sop        = 1'($urandom);
            in_eop        = 1'($urandom);
            out_read      = ($urandom_range(0, 9) < (heavy_push ? 3 : 7));
            out_address   = ($urandom_range(0, 9) < 6) ? 2'd0 : 2'($urandom);
            out_write     = ($urandom_range(0, 7) == 0);
            out_writedata = 8'($urandom);
            step();
            if (i == 800) do_reset();
        end
        in_valid = 1'b0; out_read = 1'b0; out_write = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
